vliw_logic_pipe: RTL and testbench
==================================

Name: vliw_logic_pipe

Overview:
- Parametrised, pipelined, multi-lane successor to the 64-bit combinational logic unit.
- One instance serves all VLIW issue slots: each lane performs one of eight bitwise ops per cycle on WIDTH-bit operands.
- Two-stage registered pipeline with valid/ready handshake on both sides, per-lane enable mask and an issue tag.
- Sits between the VLIW decode/operand-fetch stage and the writeback arbiter.

Parameters:
- WIDTH, 64, operand/result width per lane (≥1).
- LANES, 2, number of parallel issue slots (≥1).
- TAG_W, 4, width of the instruction tag carried alongside the bundle (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bundle present on the in_* ports.
- in_ready  out  1  pipe accepts the bundle this cycle.
- in_a  in  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
- in_b  in  LANES*WIDTH  operand B, same packing as in_a.
- in_sel  in  LANES*3  per-lane op select.
- in_en  in  LANES  per-lane enable; a disabled lane produces a zero result.
- in_tag  in  TAG_W  instruction tag.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer takes the bundle.
- out_res  out  LANES*WIDTH  per-lane results.
- out_en  out  LANES  enable mask, delayed with its bundle.
- out_tag  out  TAG_W  tag, delayed with its bundle.

Behaviour:
- Op encoding, identical for every lane:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 NOT A (B ignored).
  - 7 PASS A (B ignored).
- Stage S1 registers operands, sel, en and tag on an accepted input; handshake completes when in_valid && in_ready.
- Stage S2 registers the computed result. Computation is combinational from the S1 registers.
- Each stage has its own valid bit, s1_v and s2_v.
- Latency: exactly 2 cycles from accept to out_valid when out_ready is held high. Throughput is 1 bundle/cycle.
- Stall rules:
  - s2 advances when !s2_v || out_ready.
  - s1 advances when !s1_v || s2 advances.
  - in_ready = !s1_v || s2 advances (combinational).
- A bubble in S1 with S2 stalled still allows S1 to fill, so up to 2 bundles are in flight.
- Output stability: while out_valid && !out_ready, out_res, out_en and out_tag hold stable. out_valid never drops without a handshake.
- Simultaneous accept and drain in the same cycle: both occur. No bundle is lost or duplicated.
- Disabled lane: its result bits are 0 regardless of sel and operands. out_en reflects the mask.
- Lane independence: a lane's result depends only on that lane's slices. There is no carry or ripple between lanes.
- Reset (async, rst_n low):
  - s1_v = s2_v = 0, out_valid = 0, out_res = 0, out_en = 0, out_tag = 0.
  - in_ready = 1 once reset deasserts.
  - Reset mid-operation discards in-flight bundles.
- Data registers may be left un-gated by valid, except for the zeroing of outputs on reset.

Optional Feature:
- Macro: VLIW_LOGIC_FLAGS_EN.
- Defined:
  - Adds output out_zero [LANES], 1 when the lane result is all zeros.
  - Adds output out_par [LANES], XOR-reduction of the lane result.
  - Both are registered in S2 with the result, reset to 0 and follow the same hold rules.
  - A disabled lane reports zero=1, par=0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header (vliw_logic_pkg):
  - Op-code constants OP_AND..OP_PASS (3-bit).
  - Op select width constant = 3.
- Sub-module logic_lane:
  - Combinational; WIDTH parameter; inputs a, b, sel, en; output res (plus zero/par under the macro).
  - Instantiated LANES times via generate.
- Pipeline control and registers stay in the top module.

Test Plan:
- All ops, WIDTH=64, LANES=2, out_ready=1:
  - A=64'h0000_000F_FC00_0070, B=64'h7186_9861_DEDE_73BB, sel 0..7 on lane 0.
  - Lane 1 gets the swapped operands.
  - → results match AND/OR/XOR/NAND/NOR/XNOR/~A/A exactly, each 2 cycles after accept, tags in order.
- Backpressure:
  - Stream 5 bundles (tags 1..5) back-to-back; hold out_ready=0 for cycles 3–6.
  - → in_ready drops once 2 bundles are held; outputs hold stable; tags emerge 1..5 with no loss or duplication.
- Enable mask: in_en=2'b01, sel=1 (OR), B=all-ones → lane 0 = all-ones, lane 1 = 0, out_en = 2'b01.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously between clock edges with 2 bundles in flight.
  - → out_valid=0 and out_res=0 immediately; after release, the first new bundle appears with latency 2.
- Parameter sweep:
  - WIDTH=8, LANES=4, random ops for 1000 bundles with random out_ready.
  - → scoreboard match; per-lane isolation holds.
- VLIW_LOGIC_FLAGS_EN defined:
  - sel=0 with A=8'hF0, B=8'h0F → zero=1, par=0.
  - sel=2 with the same operands → result 8'hFF, zero=0, par=0.
  - sel=7 with A=8'h01 → par=1.

Source files
------------

// File: rtl/vliw_logic_pipe_pkg.sv
// vliw_logic_pkg: op-code constants shared by the lane datapath, the
// pipeline top and the bus interface of vliw_logic_pipe.
// Optional feature macro used elsewhere: VLIW_LOGIC_FLAGS_EN.
package vliw_logic_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_AND  = 3'd0;
  localparam logic [SEL_W-1:0] OP_OR   = 3'd1;
  localparam logic [SEL_W-1:0] OP_XOR  = 3'd2;
  localparam logic [SEL_W-1:0] OP_NAND = 3'd3;
  localparam logic [SEL_W-1:0] OP_NOR  = 3'd4;
  localparam logic [SEL_W-1:0] OP_XNOR = 3'd5;
  localparam logic [SEL_W-1:0] OP_NOTA = 3'd6;
  localparam logic [SEL_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/vliw_logic_pipe_if.sv
// vliw_logic_pipe_if: input and output handshake buses of the multi-lane
// logic pipe. The master modport is the producer/consumer side, the slave
// modport is the pipe itself.
// VLIW_LOGIC_FLAGS_EN adds the per-lane out_zero/out_par flag outputs.
interface vliw_logic_pipe_if
  import vliw_logic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 2,
  parameter int TAG_W = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic [LANES*SEL_W-1:0] in_sel;
  logic [LANES-1:0]       in_en;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_res;
  logic [LANES-1:0]       out_en;
  logic [TAG_W-1:0]       out_tag;
`ifdef VLIW_LOGIC_FLAGS_EN
  logic [LANES-1:0]       out_zero;
  logic [LANES-1:0]       out_par;
`endif

  modport master (
    output in_valid, in_a, in_b, in_sel, in_en, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_en, out_tag
`ifdef VLIW_LOGIC_FLAGS_EN
    , out_zero, out_par
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_en, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_en, out_tag
`ifdef VLIW_LOGIC_FLAGS_EN
    , out_zero, out_par
`endif
  );

endinterface

// File: rtl/vliw_logic_pipe_lane.sv
// logic_lane: combinational bitwise unit for a single issue slot.
// A disabled lane forces its result to zero.
// VLIW_LOGIC_FLAGS_EN adds the all-zero and parity flags of the result.
module logic_lane
  import vliw_logic_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
`ifdef VLIW_LOGIC_FLAGS_EN
  output logic             zero,
  output logic             par,
`endif
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] raw;

  // Op decode, then the enable mask gates the whole lane result
  always_comb begin
    raw = '0;
    case (sel)
      OP_AND:  raw = a & b;
      OP_OR:   raw = a | b;
      OP_XOR:  raw = a ^ b;
      OP_NAND: raw = ~(a & b);
      OP_NOR:  raw = ~(a | b);
      OP_XNOR: raw = ~(a ^ b);
      OP_NOTA: raw = ~a;
      OP_PASS: raw = a;
    endcase
    res = en ? raw : '0;
  end

`ifdef VLIW_LOGIC_FLAGS_EN
  // Flags come from the masked result, so a disabled lane reads zero=1, par=0
  always_comb begin
    zero = ~|res;
    par  = ^res;
  end
`endif

endmodule

// File: rtl/vliw_logic_pipe.sv
// vliw_logic_pipe: two-stage valid/ready pipeline of LANES logic lanes.
// S1 captures the accepted bundle, S2 captures the lane results; each stage
// has its own valid bit so S1 can refill while S2 is stalled.
// VLIW_LOGIC_FLAGS_EN adds registered per-lane zero/parity flags.
module vliw_logic_pipe
  import vliw_logic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  vliw_logic_pipe_if.slave bus
);

  logic                   s1_v;
  logic                   s2_v;
  logic                   s1_adv;
  logic                   s2_adv;
  logic [LANES*WIDTH-1:0] s1_a;
  logic [LANES*WIDTH-1:0] s1_b;
  logic [LANES*SEL_W-1:0] s1_sel;
  logic [LANES-1:0]       s1_en;
  logic [TAG_W-1:0]       s1_tag;
  logic [LANES*WIDTH-1:0] lane_res;
`ifdef VLIW_LOGIC_FLAGS_EN
  logic [LANES-1:0]       lane_zero;
  logic [LANES-1:0]       lane_par;
`endif

  assign s2_adv        = !s2_v || bus.out_ready;
  assign s1_adv        = !s1_v || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic_lane #(.WIDTH(WIDTH)) u_lane (
      .a    (s1_a[i*WIDTH +: WIDTH]),
      .b    (s1_b[i*WIDTH +: WIDTH]),
      .sel  (s1_sel[i*SEL_W +: SEL_W]),
      .en   (s1_en[i]),
`ifdef VLIW_LOGIC_FLAGS_EN
      .zero (lane_zero[i]),
      .par  (lane_par[i]),
`endif
      .res  (lane_res[i*WIDTH +: WIDTH])
    );
  end

  // S1: take a new bundle whenever the stage is free or moving on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sel <= '0;
      s1_en  <= '0;
      s1_tag <= '0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.in_a;
        s1_b   <= bus.in_b;
        s1_sel <= bus.in_sel;
        s1_en  <= bus.in_en;
        s1_tag <= bus.in_tag;
      end
    end
  end

  // S2: register results; outputs only change when the consumer lets go
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v         <= 1'b0;
      bus.out_res  <= '0;
      bus.out_en   <= '0;
      bus.out_tag  <= '0;
`ifdef VLIW_LOGIC_FLAGS_EN
      bus.out_zero <= '0;
      bus.out_par  <= '0;
`endif
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        bus.out_res  <= lane_res;
        bus.out_en   <= s1_en;
        bus.out_tag  <= s1_tag;
`ifdef VLIW_LOGIC_FLAGS_EN
        bus.out_zero <= lane_zero;
        bus.out_par  <= lane_par;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vliw_logic_pipe.sv
// tb_vliw_logic_pipe: directed bench for vliw_logic_pipe. A 64-bit/2-lane
// instance covers ops, backpressure, enable mask and async reset; an
// 8-bit/4-lane instance covers lane isolation and, with
// VLIW_LOGIC_FLAGS_EN defined, the zero/parity flags.
module tb_vliw_logic_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vliw_logic_pipe_if #(.WIDTH(64), .LANES(2), .TAG_W(4)) bus ();
  vliw_logic_pipe_if #(.WIDTH(8),  .LANES(4), .TAG_W(4)) nbus ();

  vliw_logic_pipe #(.WIDTH(64), .LANES(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  vliw_logic_pipe #(.WIDTH(8), .LANES(4), .TAG_W(4)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nbus.slave)
  );

  localparam logic [63:0] OPA = 64'h0000_000F_FC00_0070;
  localparam logic [63:0] OPB = 64'h7186_9861_DEDE_73BB;

  // Hand-computed results: lane 0 is op(A,B), lane 1 is op(B,A)
  logic [63:0] exp0 [8] = '{
    64'h0000_0001_DC00_0030, 64'h7186_986F_FEDE_73FB,
    64'h7186_986E_22DE_73CB, 64'hFFFF_FFFE_23FF_FFCF,
    64'h8E79_6790_0121_8C04, 64'h8E79_6791_DD21_8C34,
    64'hFFFF_FFF0_03FF_FF8F, 64'h0000_000F_FC00_0070
  };
  logic [63:0] exp1 [8] = '{
    64'h0000_0001_DC00_0030, 64'h7186_986F_FEDE_73FB,
    64'h7186_986E_22DE_73CB, 64'hFFFF_FFFE_23FF_FFCF,
    64'h8E79_6790_0121_8C04, 64'h8E79_6791_DD21_8C34,
    64'h8E79_679E_2121_8C44, 64'h7186_9861_DEDE_73BB
  };

  task automatic checkOutput(input string name, input logic [255:0] obs,
                             input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] a0,
                               input logic [63:0] b0, input logic [63:0] a1,
                               input logic [63:0] b1, input logic [2:0] s0,
                               input logic [2:0] s1, input logic [1:0] en,
                               input logic [3:0] tag);
    bus.in_valid = valid;
    bus.in_a     = {a1, a0};
    bus.in_b     = {b1, b0};
    bus.in_sel   = {s1, s0};
    bus.in_en    = en;
    bus.in_tag   = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int expo;

    bus.out_ready  = 1'b1;
    nbus.out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, 3'd0, 3'd0, 2'b00, 4'd0);
    nbus.in_valid = 1'b0;
    nbus.in_a     = '0;
    nbus.in_b     = '0;
    nbus.in_sel   = '0;
    nbus.in_en    = '0;
    nbus.in_tag   = '0;

    // Reset values
    rst_n = 1'b0;
    #12;
    checkOutput("rst_out_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("rst_out_res", 256'(bus.out_res), 256'(0));
    checkOutput("rst_out_en", 256'(bus.out_en), 256'(0));
    checkOutput("rst_out_tag", 256'(bus.out_tag), 256'(0));
    checkOutput("rst_n_out_valid", 256'(nbus.out_valid), 256'(0));
`ifdef VLIW_LOGIC_FLAGS_EN
    checkOutput("rst_out_zero", 256'(bus.out_zero), 256'(0));
    checkOutput("rst_out_par", 256'(bus.out_par), 256'(0));
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 256'(bus.in_ready), 256'(1));
    tick();

    // All eight ops back-to-back, results two cycles after accept
    for (int s = 0; s <= 8; s++) begin
      if (s < 8)
        applyStimulus(1'b1, OPA, OPB, OPB, OPA, 3'(s), 3'(s), 2'b11, 4'(s));
      else
        bus.in_valid = 1'b0;
      tick();
      if (s == 0) begin
        checkOutput("op_no_early_valid", 256'(bus.out_valid), 256'(0));
      end else begin
        checkOutput($sformatf("op%0d_valid", s - 1), 256'(bus.out_valid), 256'(1));
        checkOutput($sformatf("op%0d_res", s - 1), 256'(bus.out_res),
                    256'({exp1[s-1], exp0[s-1]}));
        checkOutput($sformatf("op%0d_tag", s - 1), 256'(bus.out_tag), 256'(s - 1));
      end
    end
    tick();
    checkOutput("op_drained", 256'(bus.out_valid), 256'(0));

    // Backpressure: five bundles, consumer stalls in cycles 3..6
    nxt  = 1;
    expo = 1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (nxt <= 5)
        applyStimulus(1'b1, 64'(nxt), '0, 64'(nxt), '0, 3'd7, 3'd7, 2'b11, 4'(nxt));
      else
        bus.in_valid = 1'b0;
      @(negedge clk);
      if (cyc <= 8)
        checkOutput($sformatf("bp_in_ready_c%0d", cyc), 256'(bus.in_ready),
                    256'((cyc >= 3 && cyc <= 6) ? 0 : 1));
      if (cyc >= 3 && cyc <= 6) begin
        checkOutput($sformatf("bp_hold_valid_c%0d", cyc), 256'(bus.out_valid), 256'(1));
        checkOutput($sformatf("bp_hold_tag_c%0d", cyc), 256'(bus.out_tag), 256'(2));
        checkOutput($sformatf("bp_hold_res_c%0d", cyc), 256'(bus.out_res),
                    256'({64'd2, 64'd2}));
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("bp_tag_c%0d", cyc), 256'(bus.out_tag), 256'(expo));
        checkOutput($sformatf("bp_res_c%0d", cyc), 256'(bus.out_res),
                    256'({64'(expo), 64'(expo)}));
        expo++;
      end
      if (bus.in_valid && bus.in_ready) nxt++;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_all_accepted", 256'(nxt), 256'(6));
    checkOutput("bp_all_drained", 256'(expo), 256'(6));
    bus.out_ready = 1'b1;

    // Enable mask: lane 1 disabled
    applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0, '1, 64'h1234_5678_9ABC_DEF0, '1,
                  3'd1, 3'd1, 2'b01, 4'hA);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("en_valid", 256'(bus.out_valid), 256'(1));
    checkOutput("en_res", 256'(bus.out_res), 256'({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}));
    checkOutput("en_mask", 256'(bus.out_en), 256'(2'b01));
    checkOutput("en_tag", 256'(bus.out_tag), 256'(4'hA));
    tick();

    // Async reset with two bundles in flight
    applyStimulus(1'b1, OPA, OPB, OPB, OPA, 3'd0, 3'd0, 2'b11, 4'd3);
    tick();
    applyStimulus(1'b1, OPA, OPB, OPB, OPA, 3'd1, 3'd1, 2'b11, 4'd4);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("rstmid_pre_valid", 256'(bus.out_valid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("rstmid_res", 256'(bus.out_res), 256'(0));
    checkOutput("rstmid_tag", 256'(bus.out_tag), 256'(0));
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("rstmid_no_ghost", 256'(bus.out_valid), 256'(0));
    applyStimulus(1'b1, OPA, OPB, OPB, OPA, 3'd2, 3'd2, 2'b11, 4'd9);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("rstmid_lat1_valid", 256'(bus.out_valid), 256'(0));
    tick();
    checkOutput("rstmid_lat2_valid", 256'(bus.out_valid), 256'(1));
    checkOutput("rstmid_lat2_res", 256'(bus.out_res), 256'({exp1[2], exp0[2]}));
    checkOutput("rstmid_lat2_tag", 256'(bus.out_tag), 256'(9));

    // Narrow instance: four independent lanes, then partial enable
    nbus.in_valid = 1'b1;
    nbus.in_a     = {8'h5A, 8'h01, 8'hF0, 8'hF0};
    nbus.in_b     = {8'h00, 8'h00, 8'h0F, 8'h0F};
    nbus.in_sel   = {3'd6, 3'd7, 3'd2, 3'd0};
    nbus.in_en    = 4'b1111;
    nbus.in_tag   = 4'd1;
    tick();
    nbus.in_en    = 4'b1010;
    nbus.in_tag   = 4'd2;
    tick();
    nbus.in_valid = 1'b0;
    checkOutput("nar1_valid", 256'(nbus.out_valid), 256'(1));
    checkOutput("nar1_res", 256'(nbus.out_res), 256'(32'hA501_FF00));
    checkOutput("nar1_tag", 256'(nbus.out_tag), 256'(1));
`ifdef VLIW_LOGIC_FLAGS_EN
    checkOutput("nar1_zero", 256'(nbus.out_zero), 256'(4'b0001));
    checkOutput("nar1_par", 256'(nbus.out_par), 256'(4'b0100));
`endif
    tick();
    checkOutput("nar2_res", 256'(nbus.out_res), 256'(32'hA500_FF00));
    checkOutput("nar2_en", 256'(nbus.out_en), 256'(4'b1010));
    checkOutput("nar2_tag", 256'(nbus.out_tag), 256'(2));
`ifdef VLIW_LOGIC_FLAGS_EN
    checkOutput("nar2_zero", 256'(nbus.out_zero), 256'(4'b0101));
    checkOutput("nar2_par", 256'(nbus.out_par), 256'(4'b0000));
`endif
    tick();
    checkOutput("nar_drained", 256'(nbus.out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
